// File: rtl/proc_arb_pkg.sv
// rtl/proc_arb_pkg.sv - shared types and constants for the process request arbiter
package proc_arb_pkg;

  localparam int NUM_SRC = 3;

  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_1    = 2'd1;
  localparam logic [1:0] SRC_2    = 2'd2;
  localparam logic [1:0] SRC_3    = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    HOLD  = 2'd2
  } arb_state_t;

  // Lowest set bit wins: source 1 has the highest fixed priority.
  function automatic logic [1:0] fixed_pick(input logic [NUM_SRC-1:0] req);
    if (req[0]) return SRC_1;
    if (req[1]) return SRC_2;
    if (req[2]) return SRC_3;
    return SRC_NONE;
  endfunction

endpackage

// File: rtl/proc_sync_edge.sv
// rtl/proc_sync_edge.sv - async input synchroniser with rising-edge detect
module proc_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic kill,
  input  logic async_in,
  output logic sync_out,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   delayed_q;

  always_ff @(posedge clk) begin
    if (kill) begin
      sync_q    <= '0;
      delayed_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], async_in};
      delayed_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign rise     = sync_out & ~delayed_q;

endmodule

// File: rtl/process_req_arbiter.sv
// rtl/process_req_arbiter.sv - latches process request edges and offers them one at a time
// Optional macro PROC_ARB_ROUND_ROBIN_EN selects rotating winner selection instead of fixed priority.
module process_req_arbiter
  import proc_arb_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int HOLDOFF_CYCLES = 4,
  parameter int DROP_CNT_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      kill,
  input  logic                      process_1,
  input  logic                      process_2,
  input  logic                      process_3,
  input  logic                      req_ready,
  output logic                      req_valid,
  output logic [1:0]                req_id,
  output logic [2:0]                pending,
  output logic [DROP_CNT_WIDTH-1:0] drop_cnt,
  output logic                      holdoff
);

  localparam logic [7:0] HOLD_LOAD = (HOLDOFF_CYCLES > 0) ? 8'(HOLDOFF_CYCLES - 1) : 8'd0;
  localparam logic [DROP_CNT_WIDTH+1:0] DROP_MAX = {2'b00, {DROP_CNT_WIDTH{1'b1}}};

  logic [NUM_SRC-1:0] proc_in;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] sync_level_unused;

  assign proc_in = {process_3, process_2, process_1};

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_sync
    proc_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk      (clk),
      .kill     (kill),
      .async_in (proc_in[g]),
      .sync_out (sync_level_unused[g]),
      .rise     (rise[g])
    );
  end

  arb_state_t               state_q, state_d;
  logic [1:0]               id_q, id_d;
  logic [7:0]               hold_q, hold_d;
  logic [NUM_SRC-1:0]       pending_q;
  logic [DROP_CNT_WIDTH-1:0] drop_q;
  logic [1:0]               winner;
  logic                     grant;
  logic [NUM_SRC-1:0]       grant_mask;
  logic [NUM_SRC-1:0]       drop_vec;
  logic [1:0]               drop_num;
  logic [DROP_CNT_WIDTH+1:0] drop_sum;

  assign grant      = (state_q == OFFER) & req_ready;
  assign grant_mask = grant ? (3'b001 << (id_q - 2'd1)) : 3'b000;
  // A rise coinciding with its own grant re-latches rather than counting as a drop.
  assign drop_vec   = rise & pending_q & ~grant_mask;
  assign drop_num   = {1'b0, drop_vec[0]} + {1'b0, drop_vec[1]} + {1'b0, drop_vec[2]};
  assign drop_sum   = {2'b00, drop_q} + {{DROP_CNT_WIDTH{1'b0}}, drop_num};

`ifdef PROC_ARB_ROUND_ROBIN_EN
  logic [1:0] last_q;

  always_ff @(posedge clk) begin
    if (kill) begin
      last_q <= SRC_3;
    end else if (grant) begin
      last_q <= id_q;
    end
  end

  always_comb begin
    winner = SRC_NONE;
    case (last_q)
      SRC_1:   winner = pending_q[1] ? SRC_2 : pending_q[2] ? SRC_3 : pending_q[0] ? SRC_1 : SRC_NONE;
      SRC_2:   winner = pending_q[2] ? SRC_3 : pending_q[0] ? SRC_1 : pending_q[1] ? SRC_2 : SRC_NONE;
      default: winner = fixed_pick(pending_q);
    endcase
  end
`else
  assign winner = fixed_pick(pending_q);
`endif

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (|pending_q) begin
          state_d = OFFER;
          id_d    = winner;
        end
      end
      OFFER: begin
        if (req_ready) begin
          id_d = SRC_NONE;
          if (HOLDOFF_CYCLES > 0) begin
            state_d = HOLD;
            hold_d  = HOLD_LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      HOLD: begin
        if (hold_q == 8'd0) begin
          state_d = IDLE;
        end else begin
          hold_d = hold_q - 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        id_d    = SRC_NONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (kill) begin
      state_q   <= IDLE;
      id_q      <= SRC_NONE;
      hold_q    <= 8'd0;
      pending_q <= '0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      hold_q    <= hold_d;
      pending_q <= (pending_q & ~grant_mask) | rise;
      drop_q    <= (drop_sum > DROP_MAX) ? {DROP_CNT_WIDTH{1'b1}} : drop_sum[DROP_CNT_WIDTH-1:0];
    end
  end

  assign req_valid = (state_q == OFFER);
  assign req_id    = id_q;
  assign pending   = pending_q;
  assign drop_cnt  = drop_q;
  assign holdoff   = (state_q == HOLD);

endmodule

// File: tb/tb_process_req_arbiter.sv
// tb/tb_process_req_arbiter.sv - scoreboard bench for process_req_arbiter
module tb_process_req_arbiter;

  logic       clk = 1'b0;
  logic       kill;
  logic       process_1, process_2, process_3;
  logic       req_ready;
  logic       req_valid;
  logic [1:0] req_id;
  logic [2:0] pending;
  logic [7:0] drop_cnt;
  logic       holdoff;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;
  int grants   = 0;
  int last_grant_cycle = 0;
  int prev_grant_cycle = 0;
  int exp_drop = 0;
  logic [1:0] exp_q[$];
  logic [1:0] exp_id;

  process_req_arbiter #(
    .SYNC_STAGES    (2),
    .HOLDOFF_CYCLES (4),
    .DROP_CNT_WIDTH (8)
  ) dut (
    .clk       (clk),
    .kill      (kill),
    .process_1 (process_1),
    .process_2 (process_2),
    .process_3 (process_3),
    .req_ready (req_ready),
    .req_valid (req_valid),
    .req_id    (req_id),
    .pending   (pending),
    .drop_cnt  (drop_cnt),
    .holdoff   (holdoff)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  // Scoreboard: every accepted transfer must match the next expected source.
  always @(negedge clk) begin
    if (kill === 1'b0 && req_valid === 1'b1 && req_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL grant_unexpected: got req_id=%0d, required no grant", req_id);
      end else begin
        exp_id = exp_q.pop_front();
        if (req_id !== exp_id) begin
          failures++;
          $display("FAIL grant_id: got req_id=%0d, required %0d", req_id, exp_id);
        end
      end
      grants++;
      prev_grant_cycle = last_grant_cycle;
      last_grant_cycle = cycle;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (n < 200 && (req_valid !== 1'b0 || holdoff !== 1'b0 || pending !== 3'b000)) begin
      step(1);
      n++;
    end
    checks++;
    if (n >= 200) begin
      failures++;
      $display("FAIL wait_idle: timeout valid=%b holdoff=%b pending=%b, required idle",
               req_valid, holdoff, pending);
    end
  endtask

  task automatic test_reset();
    kill = 1'b1;
    process_1 = 1'b0; process_2 = 1'b0; process_3 = 1'b0;
    req_ready = 1'b0;
    step(3);
    kill = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      checks++;
      if ({req_valid, req_id, pending, drop_cnt, holdoff} !== 15'd0) begin
        failures++;
        $display("FAIL reset_idle: cycle %0d valid=%b id=%0d pending=%b drop=%0d holdoff=%b, required all 0",
                 i, req_valid, req_id, pending, drop_cnt, holdoff);
      end
    end
  endtask

  task automatic test_single_pulse();
    int hc;
    req_ready = 1'b1;
    exp_q.push_back(2'd2);
    process_2 = 1'b1;
    step(2);
    checks++;
    if (pending !== 3'b000) begin
      failures++;
      $display("FAIL single_pending_early: got %b, required 000", pending);
    end
    step(1);
    checks++;
    if (pending !== 3'b010) begin
      failures++;
      $display("FAIL single_pending_set: got %b, required 010", pending);
    end
    step(1);
    checks++;
    if (req_valid !== 1'b1 || req_id !== 2'd2) begin
      failures++;
      $display("FAIL single_offer: got valid=%b id=%0d, required valid=1 id=2", req_valid, req_id);
    end
    process_2 = 1'b0;
    step(1);
    checks++;
    if (req_valid !== 1'b0 || req_id !== 2'd0 || pending !== 3'b000) begin
      failures++;
      $display("FAIL single_after_grant: got valid=%b id=%0d pending=%b, required 0 0 000",
               req_valid, req_id, pending);
    end
    hc = 0;
    for (int i = 0; i < 20; i++) begin
      if (holdoff === 1'b1) hc++;
      step(1);
    end
    checks++;
    if (hc != 4) begin
      failures++;
      $display("FAIL holdoff_len: got %0d cycles, required 4", hc);
    end
  endtask

  task automatic test_simultaneous();
    int g0;
    int n;
    req_ready = 1'b1;
    g0 = grants;
`ifdef PROC_ARB_ROUND_ROBIN_EN
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd1);
`else
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd3);
`endif
    process_1 = 1'b1; process_3 = 1'b1;
    step(2);
    process_1 = 1'b0; process_3 = 1'b0;
    n = 0;
    while (n < 60 && grants < g0 + 2) begin
      step(1);
      n++;
    end
    checks++;
    if (grants < g0 + 2) begin
      failures++;
      $display("FAIL simul_timeout: got %0d grants, required 2", grants - g0);
    end else begin
      checks++;
      if (last_grant_cycle - prev_grant_cycle != 6) begin
        failures++;
        $display("FAIL simul_spacing: got %0d cycles, required 6", last_grant_cycle - prev_grant_cycle);
      end
    end
    wait_idle();
  endtask

  task automatic test_overrun_stall();
    req_ready = 1'b0;
    exp_q.push_back(2'd3);
    for (int i = 0; i < 3; i++) begin
      process_3 = 1'b1;
      step(2);
      process_3 = 1'b0;
      step(3);
    end
    step(4);
    exp_drop = exp_drop + 2;
    checks++;
    if (drop_cnt !== 8'(exp_drop)) begin
      failures++;
      $display("FAIL overrun_drop: got %0d, required %0d", drop_cnt, exp_drop);
    end
    checks++;
    if (req_valid !== 1'b1 || req_id !== 2'd3 || pending !== 3'b100) begin
      failures++;
      $display("FAIL overrun_offer: got valid=%b id=%0d pending=%b, required 1 3 100",
               req_valid, req_id, pending);
    end
    req_ready = 1'b1;
    step(1);
    checks++;
    if (req_valid !== 1'b0) begin
      failures++;
      $display("FAIL overrun_release: got valid=%b, required 0", req_valid);
    end
    wait_idle();
  endtask

  task automatic test_saturation();
    req_ready = 1'b0;
    exp_q.push_back(2'd1);
    for (int i = 0; i < 10; i++) begin
      process_1 = 1'b1; step(1);
      process_1 = 1'b0; step(1);
    end
    step(4);
    exp_drop = exp_drop + 9;
    checks++;
    if (drop_cnt !== 8'(exp_drop)) begin
      failures++;
      $display("FAIL sat_partial: got %0d, required %0d", drop_cnt, exp_drop);
    end
    for (int i = 0; i < 250; i++) begin
      process_1 = 1'b1; step(1);
      process_1 = 1'b0; step(1);
    end
    step(4);
    exp_drop = (exp_drop + 250 > 255) ? 255 : exp_drop + 250;
    checks++;
    if (drop_cnt !== 8'(exp_drop)) begin
      failures++;
      $display("FAIL sat_full: got %0d, required %0d", drop_cnt, exp_drop);
    end
    process_1 = 1'b1; step(1);
    process_1 = 1'b0; step(5);
    checks++;
    if (drop_cnt !== 8'd255) begin
      failures++;
      $display("FAIL sat_hold: got %0d, required 255", drop_cnt);
    end
    req_ready = 1'b1;
    step(1);
    wait_idle();
  endtask

  task automatic test_kill();
    int g0;
    logic [1:0] want;
    req_ready = 1'b0;
`ifdef PROC_ARB_ROUND_ROBIN_EN
    want = 2'd2;
`else
    want = 2'd1;
`endif
    process_1 = 1'b1; process_2 = 1'b1; process_3 = 1'b1;
    step(2);
    process_1 = 1'b0; process_2 = 1'b0; process_3 = 1'b0;
    step(4);
    checks++;
    if (pending !== 3'b111 || req_valid !== 1'b1 || req_id !== want) begin
      failures++;
      $display("FAIL kill_setup: got pending=%b valid=%b id=%0d, required 111 1 %0d",
               pending, req_valid, req_id, want);
    end
    kill = 1'b1;
    step(1);
    kill = 1'b0;
    checks++;
    if ({req_valid, req_id, pending, drop_cnt, holdoff} !== 15'd0) begin
      failures++;
      $display("FAIL kill_clear: got valid=%b id=%0d pending=%b drop=%0d holdoff=%b, required all 0",
               req_valid, req_id, pending, drop_cnt, holdoff);
    end
    exp_drop = 0;
    req_ready = 1'b1;
    g0 = grants;
    step(20);
    checks++;
    if (grants != g0 || pending !== 3'b000) begin
      failures++;
      $display("FAIL kill_no_grant: got %0d grants pending=%b, required 0 grants 000",
               grants - g0, pending);
    end
  endtask

  initial begin
    test_reset();
    test_single_pulse();
    test_simultaneous();
    test_overrun_stall();
    test_saturation();
    test_kill();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_empty: got %0d outstanding, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
